// File: rtl/memory_cache_responder_if.sv
// Request, cache-side and response bundles of the memory cache responder.
// The master modport is the environment; slave is the responder itself.
interface memory_cache_responder_if #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 512,
  parameter int CU_ID_W = 8
);
  localparam int NBYTES = DATA_W / 8;

  logic               req_valid;
  logic               req_ready;
  logic [CU_ID_W-1:0] req_cu_id;
  logic [ADDR_W-1:0]  req_base_address;
  logic [ADDR_W-1:0]  req_address_offset;
  logic [31:0]        req_cmd_type;
  logic [DATA_W-1:0]  req_wdata;

  logic               cache_valid;
  logic [ADDR_W-1:0]  cache_addr;
  logic [DATA_W-1:0]  cache_wdata;
  logic [NBYTES-1:0]  cache_wstrb;
  logic [DATA_W-1:0]  cache_rdata;
  logic               cache_ready;

  logic               resp_valid;
  logic               resp_ready;
  logic [CU_ID_W-1:0] resp_cu_id;
  logic [ADDR_W-1:0]  resp_base_address;
  logic [ADDR_W-1:0]  resp_address_offset;
  logic [31:0]        resp_cmd_type;
  logic [DATA_W-1:0]  resp_data_field;
  logic [31:0]        resp_struct_type;

  modport master (
    output req_valid, req_cu_id, req_base_address, req_address_offset,
           req_cmd_type, req_wdata,
    input  req_ready,
    input  cache_valid, cache_addr, cache_wdata, cache_wstrb,
    output cache_rdata, cache_ready,
    input  resp_valid, resp_cu_id, resp_base_address, resp_address_offset,
           resp_cmd_type, resp_data_field, resp_struct_type,
    output resp_ready
  );

  modport slave (
    input  req_valid, req_cu_id, req_base_address, req_address_offset,
           req_cmd_type, req_wdata,
    output req_ready,
    output cache_valid, cache_addr, cache_wdata, cache_wstrb,
    input  cache_rdata, cache_ready,
    output resp_valid, resp_cu_id, resp_base_address, resp_address_offset,
           resp_cmd_type, resp_data_field, resp_struct_type,
    input  resp_ready
  );
endinterface

// File: rtl/memory_cache_responder.sv
// Single-outstanding responder: turns a request packet into one cache access
// and, for READ/WRITE, returns a response packet echoing the request.
module memory_cache_responder #(
  parameter int          ADDR_W         = 64,
  parameter int          DATA_W         = 512,
  parameter int          CU_ID_W        = 8,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] STRUCT_TYPE    = 32'd9
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  memory_cache_responder_if.slave   bus,
  output logic                      err_timeout,
  output logic [31:0]               req_count
);

  localparam int NBYTES = DATA_W / 8;
  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [31:0] CMD_READ           = 32'd1;
  localparam logic [31:0] CMD_WRITE          = 32'd2;
  localparam logic [31:0] CMD_PREFETCH_READ  = 32'd3;
  localparam logic [31:0] CMD_PREFETCH_WRITE = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RESP,
    S_SEND_RESP
  } state_t;

  state_t             state_q;
  state_t             state_d;

  logic               req_ready_q;
  logic               cache_valid_q;
  logic               resp_valid_q;
  logic [CU_ID_W-1:0] cu_id_q;
  logic [ADDR_W-1:0]  base_q;
  logic [ADDR_W-1:0]  offset_q;
  logic [31:0]        cmd_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [NBYTES-1:0]  wstrb_q;
  logic [DATA_W-1:0]  data_q;
  logic [WAIT_W-1:0]  wait_cnt_q;
  logic               early_done_q;

  logic               accept;
  logic               cmd_ok;
  logic               cmd_is_write;
  logic               is_prefetch;
  logic               complete;
  logic               timeout_hit;

  assign accept       = (state_q == S_IDLE) && bus.req_valid && req_ready_q;
  assign cmd_ok       = (bus.req_cmd_type >= CMD_READ) &&
                        (bus.req_cmd_type <= CMD_PREFETCH_WRITE);
  assign cmd_is_write = (bus.req_cmd_type == CMD_WRITE) ||
                        (bus.req_cmd_type == CMD_PREFETCH_WRITE);
  assign is_prefetch  = (cmd_q == CMD_PREFETCH_READ) ||
                        (cmd_q == CMD_PREFETCH_WRITE);

  // State register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A cache_ready seen while still in ISSUE is remembered in early_done_q and
  // resolved on the next cycle, keeping the minimum latency at three cycles.
  always_comb begin
    state_d     = state_q;
    complete    = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && cmd_ok) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        complete = bus.cache_ready;
        state_d  = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        if (early_done_q) begin
          state_d = is_prefetch ? S_IDLE : S_SEND_RESP;
        end else if (bus.cache_ready) begin
          complete = 1'b1;
          state_d  = is_prefetch ? S_IDLE : S_SEND_RESP;
        end else if (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_SEND_RESP: begin
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      req_ready_q   <= 1'b0;
      cache_valid_q <= 1'b0;
      resp_valid_q  <= 1'b0;
      cu_id_q       <= '0;
      base_q        <= '0;
      offset_q      <= '0;
      cmd_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      data_q        <= '0;
      wait_cnt_q    <= '0;
      early_done_q  <= 1'b0;
      err_timeout   <= 1'b0;
      req_count     <= '0;
    end else begin
      req_ready_q  <= (state_d == S_IDLE);
      resp_valid_q <= (state_d == S_SEND_RESP);
      early_done_q <= (state_q == S_ISSUE) && bus.cache_ready;

      if (accept) begin
        cu_id_q  <= bus.req_cu_id;
        base_q   <= bus.req_base_address;
        offset_q <= bus.req_address_offset;
        cmd_q    <= bus.req_cmd_type;
        addr_q   <= bus.req_base_address + bus.req_address_offset;
        wdata_q  <= bus.req_wdata;
        wstrb_q  <= cmd_is_write ? {NBYTES{1'b1}} : {NBYTES{1'b0}};
      end

      if (accept && cmd_ok) begin
        cache_valid_q <= 1'b1;
      end else if (complete || timeout_hit) begin
        cache_valid_q <= 1'b0;
      end

      if (state_q == S_ISSUE) begin
        wait_cnt_q <= '0;
      end else if (state_q == S_WAIT_RESP) begin
        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      end

      if (complete) begin
        data_q    <= (cmd_q == CMD_WRITE) ? wdata_q : bus.cache_rdata;
        req_count <= req_count + 32'd1;
      end

      if (timeout_hit) begin
        err_timeout <= 1'b1;
      end
    end
  end

  assign bus.req_ready           = req_ready_q;
  assign bus.cache_valid         = cache_valid_q;
  assign bus.cache_addr          = addr_q;
  assign bus.cache_wdata         = wdata_q;
  assign bus.cache_wstrb         = wstrb_q;
  assign bus.resp_valid          = resp_valid_q;
  assign bus.resp_cu_id          = cu_id_q;
  assign bus.resp_base_address   = base_q;
  assign bus.resp_address_offset = offset_q;
  assign bus.resp_cmd_type       = cmd_q;
  assign bus.resp_data_field     = data_q;
  assign bus.resp_struct_type    = STRUCT_TYPE;

endmodule

// File: tb/tb_memory_cache_responder.sv
// Directed bench for memory_cache_responder: read, write, prefetch, invalid,
// backpressure, timeout, address wrap and mid-transaction reset.
module tb_memory_cache_responder;

  localparam int ADDR_W  = 64;
  localparam int DATA_W  = 512;
  localparam int CU_ID_W = 8;
  localparam int NBYTES  = DATA_W / 8;
  localparam int CW      = 512;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        err_timeout;
  logic [31:0] req_count;

  int n_pass  = 0;
  int n_total = 0;

  logic [DATA_W-1:0] pat_ab = {64{8'hAB}};
  logic [DATA_W-1:0] pat_55 = {64{8'h55}};
  logic [DATA_W-1:0] pat_12 = {64{8'h12}};
  logic [DATA_W-1:0] pat_c3 = {64{8'hC3}};
  logic [NBYTES-1:0] all_strb = {NBYTES{1'b1}};

  memory_cache_responder_if #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CU_ID_W(CU_ID_W)
  ) bus ();

  memory_cache_responder #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .CU_ID_W       (CU_ID_W),
    .TIMEOUT_CYCLES(8),
    .STRUCT_TYPE   (32'd9)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .bus        (bus),
    .err_timeout(err_timeout),
    .req_count  (req_count)
  );

  always #5 ap_clk = ~ap_clk;

  // Advance one clock and settle just past the edge
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [CW-1:0] observed,
                              input logic [CW-1:0] expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic apply_stimulus(input logic [CU_ID_W-1:0] cu,
                                input logic [ADDR_W-1:0] base,
                                input logic [ADDR_W-1:0] off,
                                input logic [31:0] cmd,
                                input logic [DATA_W-1:0] wdata);
    bus.req_cu_id          = cu;
    bus.req_base_address   = base;
    bus.req_address_offset = off;
    bus.req_cmd_type       = cmd;
    bus.req_wdata          = wdata;
    bus.req_valid          = 1'b1;
  endtask

  initial begin
    ap_rst_n               = 1'b0;
    bus.req_valid          = 1'b0;
    bus.req_cu_id          = '0;
    bus.req_base_address   = '0;
    bus.req_address_offset = '0;
    bus.req_cmd_type       = '0;
    bus.req_wdata          = '0;
    bus.cache_rdata        = '0;
    bus.cache_ready        = 1'b0;
    bus.resp_ready         = 1'b1;
    tick();
    tick();

    check_output("rst_req_ready",   CW'(bus.req_ready),   CW'(1'b0));
    check_output("rst_cache_valid", CW'(bus.cache_valid), CW'(1'b0));
    check_output("rst_resp_valid",  CW'(bus.resp_valid),  CW'(1'b0));
    check_output("rst_err_timeout", CW'(err_timeout),     CW'(1'b0));
    check_output("rst_req_count",   CW'(req_count),       CW'(0));
    check_output("rst_cache_addr",  CW'(bus.cache_addr),  CW'(0));

    ap_rst_n = 1'b1;
    tick();
    check_output("post_rst_req_ready", CW'(bus.req_ready), CW'(1'b1));

    // Read with cache_ready two cycles after acceptance
    apply_stimulus(8'h01, 64'h1000, 64'h40, 32'd1, '0);
    tick();
    bus.req_valid = 1'b0;
    check_output("rd_cache_valid", CW'(bus.cache_valid), CW'(1'b1));
    check_output("rd_cache_addr",  CW'(bus.cache_addr),  CW'(64'h1040));
    check_output("rd_wstrb",       CW'(bus.cache_wstrb), CW'(0));
    check_output("rd_req_ready",   CW'(bus.req_ready),   CW'(1'b0));
    tick();
    check_output("rd_addr_stable", CW'(bus.cache_addr),  CW'(64'h1040));
    check_output("rd_valid_held",  CW'(bus.cache_valid), CW'(1'b1));
    bus.cache_rdata = pat_ab;
    bus.cache_ready = 1'b1;
    tick();
    bus.cache_ready = 1'b0;
    check_output("rd_resp_valid",  CW'(bus.resp_valid),       CW'(1'b1));
    check_output("rd_resp_data",   CW'(bus.resp_data_field),  CW'(pat_ab));
    check_output("rd_resp_cmd",    CW'(bus.resp_cmd_type),    CW'(32'd1));
    check_output("rd_resp_cu",     CW'(bus.resp_cu_id),       CW'(8'h01));
    check_output("rd_resp_base",   CW'(bus.resp_base_address), CW'(64'h1000));
    check_output("rd_struct_type", CW'(bus.resp_struct_type), CW'(32'd9));
    check_output("rd_req_count",   CW'(req_count),            CW'(1));
    check_output("rd_cache_drop",  CW'(bus.cache_valid),      CW'(1'b0));
    tick();
    check_output("rd_resp_done",   CW'(bus.resp_valid), CW'(1'b0));
    check_output("rd_ready_again", CW'(bus.req_ready),  CW'(1'b1));

    // Write with cache_ready in the same cycle cache_valid rises
    apply_stimulus(8'h05, 64'h2000, 64'h8, 32'd2, pat_55);
    tick();
    bus.req_valid = 1'b0;
    check_output("wr_wstrb", CW'(bus.cache_wstrb), CW'(all_strb));
    check_output("wr_wdata", CW'(bus.cache_wdata), CW'(pat_55));
    bus.cache_rdata = pat_12;
    bus.cache_ready = 1'b1;
    tick();
    bus.cache_ready = 1'b0;
    check_output("wr_cache_drop", CW'(bus.cache_valid), CW'(1'b0));
    check_output("wr_no_resp_yet", CW'(bus.resp_valid), CW'(1'b0));
    check_output("wr_req_count",  CW'(req_count),       CW'(2));
    tick();
    check_output("wr_resp_valid",  CW'(bus.resp_valid),         CW'(1'b1));
    check_output("wr_resp_data",   CW'(bus.resp_data_field),    CW'(pat_55));
    check_output("wr_resp_cmd",    CW'(bus.resp_cmd_type),      CW'(32'd2));
    check_output("wr_resp_cu",     CW'(bus.resp_cu_id),         CW'(8'h05));
    check_output("wr_resp_offset", CW'(bus.resp_address_offset), CW'(64'h8));
    tick();
    check_output("wr_resp_done", CW'(bus.resp_valid), CW'(1'b0));

    // Prefetch read: cache access, counted, no response
    apply_stimulus(8'h02, 64'h4000, 64'h0, 32'd3, '0);
    tick();
    bus.req_valid = 1'b0;
    check_output("pf_cache_valid", CW'(bus.cache_valid), CW'(1'b1));
    check_output("pf_wstrb",       CW'(bus.cache_wstrb), CW'(0));
    tick();
    bus.cache_ready = 1'b1;
    tick();
    bus.cache_ready = 1'b0;
    check_output("pf_cache_drop", CW'(bus.cache_valid), CW'(1'b0));
    check_output("pf_no_resp",    CW'(bus.resp_valid),  CW'(1'b0));
    check_output("pf_req_ready",  CW'(bus.req_ready),   CW'(1'b1));
    check_output("pf_req_count",  CW'(req_count),       CW'(3));
    tick();
    check_output("pf_no_resp_later", CW'(bus.resp_valid), CW'(1'b0));

    // Invalid commands are dropped
    apply_stimulus(8'h09, 64'h5000, 64'h0, 32'd0, '0);
    tick();
    bus.req_valid = 1'b0;
    check_output("inv0_cache_valid", CW'(bus.cache_valid), CW'(1'b0));
    check_output("inv0_req_ready",   CW'(bus.req_ready),   CW'(1'b1));
    apply_stimulus(8'h09, 64'h5000, 64'h0, 32'd7, '0);
    tick();
    bus.req_valid = 1'b0;
    check_output("inv7_cache_valid", CW'(bus.cache_valid), CW'(1'b0));
    check_output("inv7_req_ready",   CW'(bus.req_ready),   CW'(1'b1));
    check_output("inv_req_count",    CW'(req_count),       CW'(3));

    // Response backpressure for five cycles
    bus.resp_ready = 1'b0;
    apply_stimulus(8'h03, 64'h3000, 64'h100, 32'd1, '0);
    tick();
    bus.req_valid   = 1'b0;
    bus.cache_rdata = pat_c3;
    bus.cache_ready = 1'b1;
    tick();
    bus.cache_ready = 1'b0;
    bus.cache_rdata = pat_12;
    tick();
    for (int i = 0; i < 5; i++) begin
      check_output("bp_resp_valid", CW'(bus.resp_valid),      CW'(1'b1));
      check_output("bp_resp_data",  CW'(bus.resp_data_field), CW'(pat_c3));
      check_output("bp_req_ready",  CW'(bus.req_ready),       CW'(1'b0));
      tick();
    end
    check_output("bp_resp_offset", CW'(bus.resp_address_offset), CW'(64'h100));
    bus.resp_ready = 1'b1;
    tick();
    check_output("bp_resp_done",  CW'(bus.resp_valid), CW'(1'b0));
    check_output("bp_req_ready2", CW'(bus.req_ready),  CW'(1'b1));
    check_output("bp_req_count",  CW'(req_count),      CW'(4));

    // Timeout after eight wait cycles with no cache_ready
    apply_stimulus(8'h04, 64'h0, 64'h10, 32'd1, '0);
    tick();
    bus.req_valid = 1'b0;
    repeat (8) tick();
    check_output("to_err_before",   CW'(err_timeout),     CW'(1'b0));
    check_output("to_valid_before", CW'(bus.cache_valid), CW'(1'b1));
    tick();
    check_output("to_err",        CW'(err_timeout),     CW'(1'b1));
    check_output("to_cache_drop", CW'(bus.cache_valid), CW'(1'b0));
    check_output("to_req_ready",  CW'(bus.req_ready),   CW'(1'b1));
    check_output("to_no_resp",    CW'(bus.resp_valid),  CW'(1'b0));
    check_output("to_req_count",  CW'(req_count),       CW'(4));

    // Stray cache_ready while idle is ignored
    bus.cache_ready = 1'b1;
    tick();
    bus.cache_ready = 1'b0;
    check_output("stray_req_count", CW'(req_count),       CW'(4));
    check_output("stray_no_resp",   CW'(bus.resp_valid),  CW'(1'b0));

    // Normal read afterwards; timeout flag stays set
    apply_stimulus(8'h06, 64'h10, 64'h20, 32'd1, '0);
    tick();
    bus.req_valid   = 1'b0;
    bus.cache_rdata = pat_12;
    bus.cache_ready = 1'b1;
    tick();
    bus.cache_ready = 1'b0;
    tick();
    check_output("rd2_resp_valid", CW'(bus.resp_valid),      CW'(1'b1));
    check_output("rd2_resp_data",  CW'(bus.resp_data_field), CW'(pat_12));
    check_output("rd2_err_sticky", CW'(err_timeout),         CW'(1'b1));
    check_output("rd2_req_count",  CW'(req_count),           CW'(5));
    tick();

    // Address wrap, then reset while waiting for the cache
    apply_stimulus(8'h07, {ADDR_W{1'b1}}, 64'h2, 32'd1, '0);
    tick();
    bus.req_valid = 1'b0;
    check_output("wrap_cache_addr",  CW'(bus.cache_addr),  CW'(64'h1));
    check_output("wrap_cache_valid", CW'(bus.cache_valid), CW'(1'b1));
    tick();
    ap_rst_n = 1'b0;
    #1;
    check_output("mid_rst_cache_valid", CW'(bus.cache_valid),     CW'(1'b0));
    check_output("mid_rst_req_ready",   CW'(bus.req_ready),       CW'(1'b0));
    check_output("mid_rst_resp_valid",  CW'(bus.resp_valid),      CW'(1'b0));
    check_output("mid_rst_err",         CW'(err_timeout),         CW'(1'b0));
    check_output("mid_rst_req_count",   CW'(req_count),           CW'(0));
    check_output("mid_rst_cache_addr",  CW'(bus.cache_addr),      CW'(0));
    check_output("mid_rst_resp_data",   CW'(bus.resp_data_field), CW'(0));
    tick();
    tick();
    ap_rst_n = 1'b1;
    tick();
    check_output("rel_req_ready",   CW'(bus.req_ready),   CW'(1'b1));
    check_output("rel_cache_valid", CW'(bus.cache_valid), CW'(1'b0));
    repeat (3) tick();
    check_output("rel_no_resp", CW'(bus.resp_valid), CW'(1'b0));

    $display("[TB] %0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
